pipe_scoreboard: RTL and testbench

Parametrised issue-interlock scoreboard for the next-generation pipelined CPU. It replaces the fixed 5-stage ewreg/mwreg/ern/mrn compare logic with a depth-configurable writeback-slot shift register. This lets the ID stage issue operations of variable latency (ALU, load, multi-cycle mul/div) while it enforces RAW, WAW and single-write-port structural hazards. It sits beside the ID stage, gates the pc/IF-ID write enable, and tells the WB stage which register retires each cycle.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_sb_match.sv | 28 ++
 rtl/pipe_scoreboard.sv | 110 +++++++++++
 tb/tb_pipe_scoreboard.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_pkg : shared pipeline types, widths and latency helper        |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package pipe_pkg;

  localparam int PIPE_RNW  = 5;
  localparam int PIPE_LATW = 4;

  typedef struct packed {
    logic                valid;
    logic [PIPE_RNW-1:0] rn;
  } sb_slot_t;

  // A latency of zero still needs one slot; anything deeper than the board saturates.
  function automatic int lat_clamp(input int lat, input int maxlat);
    if (lat < 1) return 1;
    if (lat > maxlat) return maxlat;
    return lat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_sb_match.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_sb_match : compare one register number against every slot     |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module pipe_sb_match #(
  parameter int NSLOT = 8,
  parameter int RNW   = 5
) (
  input  logic [RNW-1:0]       rn,
  input  logic                 en,
  input  logic                 excl0,
  input  logic [NSLOT-1:0]     valid,
  input  logic [NSLOT*RNW-1:0] rns,
  output logic                 hit
);

  logic [NSLOT-1:0] slot_hit;

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    assign slot_hit[i] = valid[i] && (rns[i*RNW +: RNW] == rn) && !((i == 0) && excl0);
  end

  // r0 is hardwired, so it never creates a dependency.
  assign hit = en && (rn != '0) && (|slot_hit);

endmodule
`default_nettype wire

// File: rtl/pipe_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_scoreboard : writeback-slot issue interlock (RAW/WAW/struct)  |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int RNW    = PIPE_RNW,
  parameter int MAXLAT = 8,
  parameter int LATW   = PIPE_LATW,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            iss_valid,
  input  logic [RNW-1:0]  iss_rs,
  input  logic [RNW-1:0]  iss_rt,
  input  logic            iss_use_rs,
  input  logic            iss_use_rt,
  input  logic            iss_wreg,
  input  logic [RNW-1:0]  iss_rd,
  input  logic [LATW-1:0] iss_lat,
  input  logic            flush,
  output logic            stall,
  output logic            issue,
  output logic            wb_valid,
  output logic [RNW-1:0]  wb_rn,
  output logic            idle
);

  sb_slot_t slot_q [MAXLAT];
  sb_slot_t slot_d [MAXLAT];
  logic     idle_q, idle_d;

  logic [MAXLAT-1:0]     valid_vec;
  logic [MAXLAT*RNW-1:0] rns_flat;
  logic                  raw_rs, raw_rt, waw, str_haz;
  logic                  rd_trk;
  int                    lat_eff;

  for (genvar i = 0; i < MAXLAT; i++) begin : g_flat
    assign valid_vec[i]          = slot_q[i].valid;
    assign rns_flat[i*RNW +: RNW] = slot_q[i].rn;
  end

  assign lat_eff = lat_clamp(int'(iss_lat), MAXLAT);
  assign rd_trk  = (iss_rd != '0) && (int'(iss_rd) < NREG);

  pipe_sb_match #(.NSLOT(MAXLAT), .RNW(RNW)) u_match_rs (
    .rn(iss_rs), .en(iss_use_rs), .excl0(BYPASS != 0),
    .valid(valid_vec), .rns(rns_flat), .hit(raw_rs)
  );

  pipe_sb_match #(.NSLOT(MAXLAT), .RNW(RNW)) u_match_rt (
    .rn(iss_rt), .en(iss_use_rt), .excl0(BYPASS != 0),
    .valid(valid_vec), .rns(rns_flat), .hit(raw_rt)
  );

  // WAW includes slot 0: the older write must retire before a younger one is tracked.
  pipe_sb_match #(.NSLOT(MAXLAT), .RNW(RNW)) u_match_rd (
    .rn(iss_rd), .en(iss_wreg && rd_trk), .excl0(1'b0),
    .valid(valid_vec), .rns(rns_flat), .hit(waw)
  );

  // slot[L] shifts into slot[L-1] next cycle, which is where the new entry would land.
  always_comb begin
    str_haz = 1'b0;
    for (int i = 1; i < MAXLAT; i++) begin
      if (iss_wreg && (i == lat_eff) && slot_q[i].valid) str_haz = 1'b1;
    end
  end

  assign stall = iss_valid && (raw_rs || raw_rt || waw || str_haz);
  assign issue = iss_valid && !stall && !flush;

  always_comb begin
    for (int i = 0; i < MAXLAT - 1; i++) slot_d[i] = slot_q[i+1];
    slot_d[MAXLAT-1] = '0;
    if (issue && iss_wreg && rd_trk) begin
      for (int i = 0; i < MAXLAT; i++) begin
        if (i == lat_eff - 1) begin
          slot_d[i].valid = 1'b1;
          slot_d[i].rn    = iss_rd;
        end
      end
    end
    idle_d = 1'b1;
    for (int i = 0; i < MAXLAT; i++) begin
      if (slot_d[i].valid) idle_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clrn) begin
      for (int i = 0; i < MAXLAT; i++) slot_q[i] <= '0;
      idle_q <= 1'b1;
    end else begin
      slot_q <= slot_d;
      idle_q <= idle_d;
    end
  end

  assign wb_valid = slot_q[0].valid;
  assign wb_rn    = slot_q[0].rn;
  assign idle     = idle_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pipe_scoreboard : two boards (BYPASS=1, BYPASS=0) on one stream |
// | Revision           : 1.0                                           |
// +--------------------------------------------------------------------+
module tb_pipe_scoreboard;

  localparam int MAXLAT = 8;

  logic       clk = 1'b0;
  logic       clrn, iss_valid, iss_use_rs, iss_use_rt, iss_wreg, flush;
  logic [4:0] iss_rs, iss_rt, iss_rd;
  logic [3:0] iss_lat;

  logic [1:0] stall_v, issue_v, wb_valid_v, idle_v;
  logic [4:0] wb_rn0, wb_rn1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Per board, per register: the cycle its pending write retires (-1 = none).
  int due [2][32];
  bit exp_iss [2];

  typedef struct {int b; int rn; int due;} ent_t;
  ent_t sbq[$];

  always #5 clk = ~clk;

  pipe_scoreboard #(.BYPASS(1)) u_dut_byp (
    .clk(clk), .clrn(clrn), .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt),
    .iss_use_rs(iss_use_rs), .iss_use_rt(iss_use_rt), .iss_wreg(iss_wreg), .iss_rd(iss_rd),
    .iss_lat(iss_lat), .flush(flush), .stall(stall_v[0]), .issue(issue_v[0]),
    .wb_valid(wb_valid_v[0]), .wb_rn(wb_rn0), .idle(idle_v[0])
  );

  pipe_scoreboard #(.BYPASS(0)) u_dut_nobyp (
    .clk(clk), .clrn(clrn), .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt),
    .iss_use_rs(iss_use_rs), .iss_use_rt(iss_use_rt), .iss_wreg(iss_wreg), .iss_rd(iss_rd),
    .iss_lat(iss_lat), .flush(flush), .stall(stall_v[1]), .issue(issue_v[1]),
    .wb_valid(wb_valid_v[1]), .wb_rn(wb_rn1), .idle(idle_v[1])
  );

  task automatic chk(input string nm, input int b, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s board%0d cycle %0d: got %0d expected %0d", nm, b, cyc, act, exp);
    end
  endtask

  function automatic int lclamp(input int x);
    if (x == 0) return 1;
    if (x > MAXLAT) return MAXLAT;
    return x;
  endfunction

  // Board 0 may read a value retiring this cycle; board 1 must wait one more.
  function automatic bit m_stall(input int b);
    int  l     = lclamp(int'(iss_lat));
    int  ready = (b == 0) ? cyc + 1 : cyc;
    bit  haz   = 1'b0;
    if (iss_use_rs && iss_rs != 0 && due[b][iss_rs] >= ready) haz = 1'b1;
    if (iss_use_rt && iss_rt != 0 && due[b][iss_rt] >= ready) haz = 1'b1;
    if (iss_wreg && iss_rd != 0 && due[b][iss_rd] >= cyc) haz = 1'b1;
    if (iss_wreg && l < MAXLAT)
      for (int r = 1; r < 32; r++) if (due[b][r] == cyc + l) haz = 1'b1;
    return iss_valid && haz;
  endfunction

  function automatic bit m_idle(input int b);
    for (int r = 1; r < 32; r++) if (due[b][r] >= cyc) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model update and scoreboard push at each rising edge.
  initial begin
    for (int b = 0; b < 2; b++) for (int r = 0; r < 32; r++) due[b][r] = -1;
    forever begin
      @(posedge clk);
      if (clrn) begin
        for (int b = 0; b < 2; b++) for (int r = 0; r < 32; r++) due[b][r] = -1;
        sbq.delete();
      end else begin
        for (int b = 0; b < 2; b++) begin
          if (exp_iss[b] && iss_wreg && iss_rd != 0) begin
            due[b][iss_rd] = cyc + lclamp(int'(iss_lat));
            sbq.push_back('{b: b, rn: int'(iss_rd), due: due[b][iss_rd]});
          end
        end
      end
      cyc++;
    end
  end

  // Monitor: compare combinational and registered outputs mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int b = 0; b < 2; b++) begin
        bit es, ei;
        int idx;
        es = m_stall(b);
        ei = iss_valid && !es && !flush;
        exp_iss[b] = ei;
        chk("stall", b, int'(stall_v[b]), int'(es));
        chk("issue", b, int'(issue_v[b]), int'(ei));
        chk("idle", b, int'(idle_v[b]), int'(m_idle(b)));
        idx = -1;
        foreach (sbq[j]) if (sbq[j].b == b && sbq[j].due == cyc) idx = j;
        chk("wb_valid", b, int'(wb_valid_v[b]), int'(idx >= 0));
        if (wb_valid_v[b] && idx >= 0) begin
          chk("wb_rn", b, int'((b == 0) ? wb_rn0 : wb_rn1), sbq[idx].rn);
          sbq.delete(idx);
        end
        for (int j = sbq.size() - 1; j >= 0; j--)
          if (sbq[j].b == b && sbq[j].due <= cyc) sbq.delete(j);
      end
    end
  end

  task automatic drv(input bit v, input bit wreg, input int rd, input int lat,
                     input bit urs = 1'b0, input int rs = 0, input bit fl = 1'b0,
                     input int n = 1);
    iss_valid  = v;
    iss_wreg   = wreg;
    iss_rd     = 5'(rd);
    iss_lat    = 4'(lat);
    iss_use_rs = urs;
    iss_rs     = 5'(rs);
    iss_use_rt = 1'b0;
    iss_rt     = 5'd0;
    flush      = fl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int lats [4] = '{1, 3, 8, 12};
    clrn = 1'b1;
    drv(1, 1, 5, 3, 0, 0, 0, 2);
    clrn = 1'b0;
    for (int b = 0; b < 2; b++) begin
      chk("rst_wb_valid", b, int'(wb_valid_v[b]), 0);
      chk("rst_idle", b, int'(idle_v[b]), 1);
    end
    drv(0, 0, 0, 0, 0, 0, 0, 6);

    foreach (lats[k]) begin
      drv(1, 1, 7, lats[k]);
      drv(0, 0, 0, 0, 0, 0, 0, 12);
    end

    drv(1, 1, 4, 3);
    drv(1, 0, 0, 1, 1, 4, 0, 5);
    drv(0, 0, 0, 0, 0, 0, 0, 4);

    drv(1, 1, 2, 4);
    drv(1, 1, 3, 3, 0, 0, 0, 2);
    drv(0, 0, 0, 0, 0, 0, 0, 8);

    drv(1, 1, 9, 5);
    drv(1, 1, 9, 1, 0, 0, 0, 6);
    drv(1, 1, 0, 2, 1, 0, 0, 3);
    drv(0, 0, 0, 0, 0, 0, 0, 4);

    drv(1, 1, 6, 5);
    drv(1, 1, 6, 2, 0, 0, 1, 2);
    drv(1, 1, 10, 2, 0, 0, 1, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 8);

    for (int k = 0; k < 3000; k++) begin
      clrn       = ($urandom_range(0, 99) == 0);
      iss_valid  = ($urandom_range(0, 9) < 7);
      iss_use_rs = $urandom_range(0, 1) == 1;
      iss_use_rt = $urandom_range(0, 1) == 1;
      iss_rs     = 5'($urandom_range(0, 7));
      iss_rt     = 5'($urandom_range(0, 7));
      iss_wreg   = ($urandom_range(0, 3) != 0);
      iss_rd     = 5'($urandom_range(0, 7));
      iss_lat    = 4'($urandom_range(0, 12));
      flush      = ($urandom_range(0, 9) == 0);
      @(posedge clk);
      #1;
    end
    clrn = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
